// File: rtl/video_timing_pkg.sv
// Shared raster timing constants, derived totals and sync windows, and the
// 10-bit position type used by the video timing generator.
package video_timing_pkg;

    typedef logic [9:0] pos_t;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // Inclusive window test on a raster coordinate.
    function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster position and strobe bundle driven by video_timing_gen (master) and
// consumed by position-driven logic (slave).
interface video_timing_if;
    import video_timing_pkg::*;

    pos_t        shpos;
    pos_t        svpos;
    logic        hsync;
    logic        vsync;
    logic        display_on;
    logic        pix_tick;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        output shpos, svpos, hsync, vsync, display_on,
               pix_tick, line_start, frame_start, frame_cnt
    );

    modport slave (
        input  shpos, svpos, hsync, vsync, display_on,
               pix_tick, line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/pixel_ce_div.sv
// Pixel clock-enable divider: div_cnt runs 0..CLK_DIV-1 and tick marks the
// clk edge on which the raster advances (div_cnt == CLK_DIV-1).
module pixel_ce_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_cnt_r;

    assign tick = (div_cnt_r == DIV_LAST);

    // Free-running pixel divider, restarted by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= 4'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 4'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 4'd1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: position counters, sync/blank decode and
// line/frame strobes, all registered from the next counter values so every
// output is coherent with shpos/svpos in the same cycle.
// Optional feature: define VIDEO_TIMING_FRAME_CNT_EN to build the 8-bit
// frame counter; otherwise frame_cnt is tied to zero.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_DISPLAY = DEF_H_DISPLAY,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_DISPLAY = DEF_V_DISPLAY,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    video_timing_if.master     vt
);

    localparam int   H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam pos_t H_LAST       = pos_t'(H_TOTAL - 1);
    localparam pos_t V_LAST       = pos_t'(V_TOTAL - 1);
    localparam pos_t H_VIS        = pos_t'(H_DISPLAY);
    localparam pos_t V_VIS        = pos_t'(V_DISPLAY);
    localparam pos_t H_SYNC_START = pos_t'(H_DISPLAY + H_FRONT);
    localparam pos_t H_SYNC_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam pos_t V_SYNC_START = pos_t'(V_DISPLAY + V_FRONT);
    localparam pos_t V_SYNC_END   = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic tick_s;
    logic h_wrap_s;
    logic v_wrap_s;
    pos_t shpos_nxt_s;
    pos_t svpos_nxt_s;

    pos_t shpos_r;
    pos_t svpos_r;
    logic hsync_r;
    logic vsync_r;
    logic display_on_r;
    logic pix_tick_r;
    logic line_start_r;
    logic frame_start_r;

    pixel_ce_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s)
    );

    // Next raster position and wrap flags for the coming advance edge.
    always_comb begin
        h_wrap_s    = 1'b0;
        v_wrap_s    = 1'b0;
        shpos_nxt_s = shpos_r;
        svpos_nxt_s = svpos_r;
        if (shpos_r == H_LAST) begin
            h_wrap_s    = 1'b1;
            shpos_nxt_s = 10'd0;
            if (svpos_r == V_LAST) begin
                v_wrap_s    = 1'b1;
                svpos_nxt_s = 10'd0;
            end else begin
                svpos_nxt_s = svpos_r + 10'd1;
            end
        end else begin
            shpos_nxt_s = shpos_r + 10'd1;
        end
    end

    // Position counters and decoded outputs, updated only on advance edges;
    // the single-cycle strobes drop on every other edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shpos_r       <= 10'd0;
            svpos_r       <= 10'd0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            display_on_r  <= 1'b1;
            pix_tick_r    <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (tick_s) begin
            shpos_r       <= shpos_nxt_s;
            svpos_r       <= svpos_nxt_s;
            hsync_r       <= in_window(shpos_nxt_s, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            vsync_r       <= in_window(svpos_nxt_s, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            display_on_r  <= (shpos_nxt_s < H_VIS) && (svpos_nxt_s < V_VIS);
            pix_tick_r    <= 1'b1;
            line_start_r  <= h_wrap_s;
            frame_start_r <= v_wrap_s;
        end else begin
            pix_tick_r    <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_r;

    // Frame counter steps in the same clk that frame_start pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_r <= 8'd0;
        end else if (tick_s && v_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign vt.frame_cnt = frame_cnt_r;
`else
    assign vt.frame_cnt = 8'd0;
`endif

    assign vt.shpos       = shpos_r;
    assign vt.svpos       = svpos_r;
    assign vt.hsync       = hsync_r;
    assign vt.vsync       = vsync_r;
    assign vt.display_on  = display_on_r;
    assign vt.pix_tick    = pix_tick_r;
    assign vt.line_start  = line_start_r;
    assign vt.frame_start = frame_start_r;

endmodule
